rf_sp_lifo: RTL and testbench

- Parametrised LIFO stack built on an internal single-port register-file array with one memory access per cycle.
- Push/pop valid-ready handshakes; registered pop data with 1-cycle latency.
- Simultaneous push+pop forwards the pushed word directly to the pop output.
- Provides occupancy, full/empty, a high-watermark and sticky overflow/underflow flags. Sits between CCM producers and consumers that need last-in-first-out buffering.

---
 rtl/rf_sp_lifo.sv | 144 ++++++++++++++
 tb/tb_rf_sp_lifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_sp_lifo.sv
// rtl/rf_sp_lifo.sv - LIFO stack over a single-port register file with registered pop data.
// One memory access per cycle; a simultaneous push+pop bypasses the array entirely.

module rf_sp_lifo_rf #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          CLK,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge CLK) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

module rf_sp_lifo #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          CLEAR,
  input  logic          PUSH_VALID,
  output logic          PUSH_READY,
  input  logic [DW-1:0] PUSH_DATA,
  input  logic          POP_VALID,
  output logic          POP_READY,
  output logic [DW-1:0] RDATA,
  output logic          RDATA_VALID,
  output logic [AW:0]   COUNT,
  output logic          FULL,
  output logic          EMPTY,
  output logic [AW:0]   MAX_COUNT,
  output logic          OVF,
  output logic          UDF
);

  localparam logic [AW:0] C_DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] C_ONE   = {{AW{1'b0}}, 1'b1};

  logic [AW:0]   r_sp;
  logic [AW:0]   r_max;
  logic [DW-1:0] r_rdata;
  logic          r_rvalid;
  logic          r_ovf;
  logic          r_udf;

  logic          w_full;
  logic          w_empty;
  logic          w_push_acc;
  logic          w_pop_acc;
  logic          w_mem_we;
  logic          w_mem_re;
  logic [AW:0]   w_sp_dec;
  logic [AW:0]   w_sp_nxt;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_rdata;

  assign w_full     = (r_sp == C_DEPTH);
  assign w_empty    = (r_sp == '0);
  assign PUSH_READY = !w_full && !CLEAR;
  assign POP_READY  = !w_empty && !CLEAR;
  assign w_push_acc = PUSH_VALID && PUSH_READY;
  assign w_pop_acc  = POP_VALID && POP_READY;

  // Paired push+pop never touches the array, so the port is free for exactly one op.
  assign w_mem_we   = w_push_acc && !w_pop_acc;
  assign w_mem_re   = w_pop_acc && !w_push_acc;
  assign w_sp_dec   = r_sp - C_ONE;
  assign w_mem_addr = w_mem_we ? r_sp[AW-1:0] : w_sp_dec[AW-1:0];

  always_comb begin
    w_sp_nxt = r_sp;
    if (w_mem_we) begin
      w_sp_nxt = r_sp + C_ONE;
    end else if (w_mem_re) begin
      w_sp_nxt = w_sp_dec;
    end
  end

  rf_sp_lifo_rf #(
    .DW(DW),
    .AW(AW)
  ) u_rf (
    .CLK     (CLK),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (PUSH_DATA),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_sp     <= '0;
      r_max    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (CLEAR) begin
      r_sp     <= '0;
      r_max    <= '0;
      r_rvalid <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_sp     <= w_sp_nxt;
      r_rvalid <= w_pop_acc;
      if (w_sp_nxt > r_max) begin
        r_max <= w_sp_nxt;
      end
      if (w_pop_acc) begin
        r_rdata <= w_push_acc ? PUSH_DATA : w_mem_rdata;
      end
      if (PUSH_VALID && w_full) begin
        r_ovf <= 1'b1;
      end
      if (POP_VALID && w_empty) begin
        r_udf <= 1'b1;
      end
    end
  end

  assign COUNT       = r_sp;
  assign FULL        = w_full;
  assign EMPTY       = w_empty;
  assign MAX_COUNT   = r_max;
  assign RDATA       = r_rdata;
  assign RDATA_VALID = r_rvalid;
  assign OVF         = r_ovf;
  assign UDF         = r_udf;

endmodule

// File: tb/tb_rf_sp_lifo.sv
// tb/tb_rf_sp_lifo.sv - directed plus randomized check of rf_sp_lifo against a queue-based stack model.

module tb_rf_sp_lifo;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          CLEAR;
  logic          PUSH_VALID;
  logic          PUSH_READY;
  logic [DW-1:0] PUSH_DATA;
  logic          POP_VALID;
  logic          POP_READY;
  logic [DW-1:0] RDATA;
  logic          RDATA_VALID;
  logic [AW:0]   COUNT;
  logic          FULL;
  logic          EMPTY;
  logic [AW:0]   MAX_COUNT;
  logic          OVF;
  logic          UDF;

  always #5 CLK = ~CLK;

  rf_sp_lifo #(.DW(DW), .AW(AW)) dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .CLEAR       (CLEAR),
    .PUSH_VALID  (PUSH_VALID),
    .PUSH_READY  (PUSH_READY),
    .PUSH_DATA   (PUSH_DATA),
    .POP_VALID   (POP_VALID),
    .POP_READY   (POP_READY),
    .RDATA       (RDATA),
    .RDATA_VALID (RDATA_VALID),
    .COUNT       (COUNT),
    .FULL        (FULL),
    .EMPTY       (EMPTY),
    .MAX_COUNT   (MAX_COUNT),
    .OVF         (OVF),
    .UDF         (UDF)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] stk[$];
  int            m_max;
  bit            m_ovf;
  bit            m_udf;
  bit            m_rv;
  logic [DW-1:0] m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_max = 0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rv  = 1'b0;
    m_rd  = '0;
  endtask

  task automatic model_step(input bit pv, input bit ppv, input bit clr, input logic [DW-1:0] d);
    bit pa;
    bit pp;
    if (clr) begin
      stk.delete();
      m_max = 0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_rv  = 1'b0;
    end else begin
      pa = pv && (stk.size() < DEPTH);
      pp = ppv && (stk.size() > 0);
      if (pv && stk.size() == DEPTH) m_ovf = 1'b1;
      if (ppv && stk.size() == 0) m_udf = 1'b1;
      if (pa && pp) begin
        m_rd = d;
        m_rv = 1'b1;
      end else if (pa) begin
        stk.push_back(d);
        m_rv = 1'b0;
      end else if (pp) begin
        m_rd = stk.pop_back();
        m_rv = 1'b1;
      end else begin
        m_rv = 1'b0;
      end
      if (stk.size() > m_max) m_max = stk.size();
    end
  endtask

  task automatic check_state();
    chk("count",  32'(COUNT),       32'(stk.size()));
    chk("full",   32'(FULL),        32'(stk.size() == DEPTH));
    chk("empty",  32'(EMPTY),       32'(stk.size() == 0));
    chk("max",    32'(MAX_COUNT),   32'(m_max));
    chk("ovf",    32'(OVF),         32'(m_ovf));
    chk("udf",    32'(UDF),         32'(m_udf));
    chk("rvalid", 32'(RDATA_VALID), 32'(m_rv));
    chk("rdata",  32'(RDATA),       32'(m_rd));
  endtask

  // Drive one cycle just after a falling edge, check outputs at the next falling edge.
  task automatic run(input bit pv, input bit ppv, input bit clr, input logic [DW-1:0] d);
    PUSH_VALID = pv;
    POP_VALID  = ppv;
    CLEAR      = clr;
    PUSH_DATA  = d;
    #1;
    chk("push_ready", 32'(PUSH_READY), 32'((stk.size() < DEPTH) && !clr));
    chk("pop_ready",  32'(POP_READY),  32'((stk.size() > 0) && !clr));
    model_step(pv, ppv, clr, d);
    @(negedge CLK);
    check_state();
  endtask

  initial begin
    int push_pct;
    RSTN       = 1'b0;
    CLEAR      = 1'b0;
    PUSH_VALID = 1'b0;
    POP_VALID  = 1'b0;
    PUSH_DATA  = '0;
    model_reset();
    @(negedge CLK);
    check_state();
    RSTN = 1'b1;

    run(1, 0, 0, 8'h11);
    run(1, 0, 0, 8'h22);
    run(1, 0, 0, 8'h33);
    run(0, 1, 0, 0); chk("t1_pop0", 32'(RDATA), 32'h33);
    run(0, 1, 0, 0); chk("t1_pop1", 32'(RDATA), 32'h22);
    run(0, 1, 0, 0); chk("t1_pop2", 32'(RDATA), 32'h11);
    chk("t1_max", 32'(MAX_COUNT), 32'd3);
    run(0, 0, 0, 0);

    for (int i = 0; i < DEPTH; i++) run(1, 0, 0, DW'(i));
    chk("t2_full", 32'(FULL), 32'd1);
    run(1, 0, 0, 8'hEE);
    chk("t2_ovf", 32'(OVF), 32'd1);
    chk("t2_count", 32'(COUNT), 32'd8);
    run(0, 1, 0, 0); chk("t2_pop", 32'(RDATA), 32'h07);
    run(0, 0, 1, 0);

    run(0, 1, 0, 0);
    chk("t3_udf", 32'(UDF), 32'd1);
    run(1, 0, 0, 8'h5A);
    run(0, 1, 0, 0); chk("t3_pop", 32'(RDATA), 32'h5A);
    chk("t3_udf_sticky", 32'(UDF), 32'd1);
    run(0, 0, 1, 0);

    run(1, 0, 0, 8'hA0);
    run(1, 0, 0, 8'hA1);
    run(1, 1, 0, 8'hB5);
    chk("t4_bypass", 32'(RDATA), 32'hB5);
    chk("t4_count", 32'(COUNT), 32'd2);
    run(0, 1, 0, 0); chk("t4_pop", 32'(RDATA), 32'hA1);
    run(0, 0, 1, 0);

    for (int i = 0; i < 5; i++) run(1, 0, 0, DW'(8'h40 + i));
    run(0, 1, 0, 0);
    run(0, 1, 0, 0);
    run(0, 0, 1, 0);
    chk("t5_count", 32'(COUNT), 32'd0);
    chk("t5_max", 32'(MAX_COUNT), 32'd0);
    run(1, 0, 0, 8'h3C);
    run(0, 1, 0, 0); chk("t5_pop", 32'(RDATA), 32'h3C);

    run(1, 0, 0, 8'h61);
    run(1, 0, 0, 8'h62);
    run(0, 1, 0, 0);
    chk("t6_pending", 32'(RDATA_VALID), 32'd1);
    PUSH_VALID = 1'b0;
    POP_VALID  = 1'b0;
    RSTN       = 1'b0;
    #1;
    model_reset();
    check_state();
    @(negedge CLK);
    RSTN = 1'b1;
    check_state();

    push_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) push_pct = 20 + 30 * $urandom_range(0, 2);
      run($urandom_range(0, 99) < push_pct,
          $urandom_range(0, 99) < (100 - push_pct),
          $urandom_range(0, 149) == 0,
          DW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
